// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
//   Shared definitions for the accumulator CPU sequencer:
//     - ISA opcode values (ir[7:4])
//     - instruction_en bit indices consumed by alu (ADD=0 ... XOR=7)
//     - alu flag vector layout
//     - sequencer FSM state encoding
//     - decoded-instruction record passed from instr_decoder to control_unit
// -----------------------------------------------------------------------------
package control_unit_pkg;

    // Bus widths shared with alu
    localparam int ISA_INSTRUCTION_COUNT = 8;
    localparam int ALU_FLAG_COUNT        = 2;
    localparam int ALU_FLAG_EQ           = 0;
    localparam int ALU_FLAG_GT           = 1;

    // Opcodes (ir[7:4]); 0xC-0xE are unassigned and decode as illegal
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SH   = 4'h3;
    localparam logic [3:0] OP_SHI  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BGT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // instruction_en bit positions (one per ALU operation)
    localparam int ISA_ADD  = 0;
    localparam int ISA_ADDI = 1;
    localparam int ISA_SH   = 2;
    localparam int ISA_SHI  = 3;
    localparam int ISA_NOT  = 4;
    localparam int ISA_AND  = 5;
    localparam int ISA_OR   = 6;
    localparam int ISA_XOR  = 7;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    // Everything the sequencer needs to know about the opcode in ir
    typedef struct packed {
        logic [ISA_INSTRUCTION_COUNT-1:0] instr_en;
        logic                             acc_we;
        logic                             bus_src_imm;
        logic                             is_beq;
        logic                             is_bgt;
        logic                             is_jmp;
        logic                             is_hlt;
        logic                             is_xor;
        logic                             illegal;
    } decode_t;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// -----------------------------------------------------------------------------
// control_unit_instr_decoder
//   Purely combinational opcode decoder. Maps ir[7:4] to the one-hot ALU
//   operation select plus the control bits the sequencer needs. Outputs are
//   not gated by FSM state here; control_unit qualifies them.
// Ports
//   opcode_i  in   4         instruction opcode (ir[7:4])
//   dec_o     out  decode_t  decoded control record
// -----------------------------------------------------------------------------
module control_unit_instr_decoder
    import control_unit_pkg::*;
(
    input  logic [3:0] opcode_i,
    output decode_t    dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OP_NOP: begin
            end
            OP_ADD: begin
                dec_o.instr_en[ISA_ADD] = 1'b1;
                dec_o.acc_we            = 1'b1;
            end
            OP_ADDI: begin
                dec_o.instr_en[ISA_ADDI] = 1'b1;
                dec_o.acc_we             = 1'b1;
                dec_o.bus_src_imm        = 1'b1;
            end
            OP_SH: begin
                dec_o.instr_en[ISA_SH] = 1'b1;
                dec_o.acc_we           = 1'b1;
            end
            OP_SHI: begin
                dec_o.instr_en[ISA_SHI] = 1'b1;
                dec_o.acc_we            = 1'b1;
                dec_o.bus_src_imm       = 1'b1;
            end
            OP_NOT: begin
                dec_o.instr_en[ISA_NOT] = 1'b1;
                dec_o.acc_we            = 1'b1;
            end
            OP_AND: begin
                dec_o.instr_en[ISA_AND] = 1'b1;
                dec_o.acc_we            = 1'b1;
            end
            OP_OR: begin
                dec_o.instr_en[ISA_OR] = 1'b1;
                dec_o.acc_we           = 1'b1;
            end
            OP_XOR: begin
                // Compare-only: alu computes flags, accumulator is untouched
                dec_o.instr_en[ISA_XOR] = 1'b1;
                dec_o.is_xor            = 1'b1;
            end
            OP_BEQ: dec_o.is_beq = 1'b1;
            OP_BGT: dec_o.is_bgt = 1'b1;
            OP_JMP: dec_o.is_jmp = 1'b1;
            OP_HLT: dec_o.is_hlt = 1'b1;
            default: dec_o.illegal = 1'b1;   // 0xC-0xE
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//   Fetches one instruction per FETCH over a req/valid handshake, decodes it
//   into the one-hot alu op select, drives operand bus select and accumulator
//   write enable, latches alu flags on XOR and resolves BEQ/BGT/JMP/HLT.
// Ports
//   clk              in   1               system clock, rising edge
//   rst_n            in   1               asynchronous active-low reset
//   imem_req         out  1               fetch request, high in FETCH
//   imem_addr        out  PC_WIDTH        fetch address (= pc)
//   imem_rdata       in   8               instruction word
//   imem_valid       in   1               fetch data valid
//   instruction_en   out  8               one-hot alu op select (EXECUTE only)
//   reg_sel          out  4               register index (= ir[3:0])
//   bus_src_imm      out  1               bus carries immediate ir[3:0]
//   acc_we           out  1               accumulator write enable
//   alu_flags        in   2               alu flags {GT, EQ}
//   halted           out  1               HLT executed
//   illegal_op       out  1               pulse in EXECUTE for opcodes 0xC-0xE
// -----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             imem_req,
    output logic [PC_WIDTH-1:0]              imem_addr,
    input  logic [7:0]                       imem_rdata,
    input  logic                             imem_valid,
    output logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
    output logic [3:0]                       reg_sel,
    output logic                             bus_src_imm,
    output logic                             acc_we,
    input  logic [ALU_FLAG_COUNT-1:0]        alu_flags,
    output logic                             halted,
    output logic                             illegal_op
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_e                      state_q, state_d;
    logic [PC_WIDTH-1:0]         pc_q, pc_d;
    logic [7:0]                  ir_q, ir_d;
    logic [ALU_FLAG_COUNT-1:0]   flag_q, flag_d;
    // Holds imem_req low from reset release until the first clock edge
    logic                        started_q;

    decode_t                     dec;
    logic                        in_execute;
    logic                        fetch_fire;
    logic                        branch_taken;
    logic [PC_WIDTH-1:0]         branch_off;

    control_unit_instr_decoder u_decoder (
        .opcode_i (ir_q[7:4]),
        .dec_o    (dec)
    );

    assign in_execute = (state_q == ST_EXECUTE);
    assign fetch_fire = imem_req & imem_valid;

    // Branch offset is a signed 4-bit field relative to the branch's own pc
    assign branch_off   = {{(PC_WIDTH-4){ir_q[3]}}, ir_q[3:0]};
    assign branch_taken = dec.is_jmp
                        | (dec.is_beq & flag_q[ALU_FLAG_EQ])
                        | (dec.is_bgt & flag_q[ALU_FLAG_GT]);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            flag_q    <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flag_q    <= flag_d;
            started_q <= 1'b1;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:   if (fetch_fire) state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = dec.is_hlt ? ST_HALT : ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------ datapath update
    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        flag_d = flag_q;
        if (fetch_fire) begin
            ir_d = imem_rdata;
        end
        if (in_execute) begin
            pc_d = branch_taken ? (pc_q + branch_off) : (pc_q + PC_ONE);
            if (dec.is_xor) begin
                flag_d = alu_flags;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        imem_req       = (state_q == ST_FETCH) & started_q;
        imem_addr      = pc_q;
        instruction_en = '0;
        acc_we         = 1'b0;
        illegal_op     = 1'b0;
        reg_sel        = '0;
        bus_src_imm    = 1'b0;
        halted         = (state_q == ST_HALT);
        // Operand select is driven from DECODE so the bus settles before EXECUTE
        if ((state_q == ST_DECODE) || in_execute) begin
            reg_sel     = ir_q[3:0];
            bus_src_imm = dec.bus_src_imm;
        end
        if (in_execute) begin
            instruction_en = dec.instr_en;
            acc_we         = dec.acc_we;
            illegal_op     = dec.illegal;
        end
    end

endmodule
